// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the data-memory responder: FSM states,
// word width and the location/size of the exported 3x3 result matrix.
package mips_mem_pkg;

  localparam int WORD_W    = 32;
  localparam int MAT_BASE  = 0;
  localparam int MAT_WORDS = 9;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // True when any address bit at or above the index width is set.
  function automatic logic addr_out_of_range(input logic [WORD_W-1:0] addr,
                                             input int                idx_w);
    return (addr >> idx_w) != '0;
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// DEPTH x 32 register array with async clear, one write port, one
// combinational read port, and words MAT_BASE..MAT_BASE+8 exported flat.
module mem_word_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        we,
  input  logic [IDX_W-1:0]            waddr,
  input  logic [WORD_W-1:0]           wdata,
  input  logic [IDX_W-1:0]            raddr,
  output logic [WORD_W-1:0]           rdata,
  output logic [MAT_WORDS*WORD_W-1:0] matrix
);

  logic [WORD_W-1:0] mem [DEPTH];

  // NOTE: clearing every word on reset forces this into flip-flops rather
  // than a RAM macro; that is intended, since the matrix words must read 0
  // immediately after reset and are exported combinationally.
  // NOTE: sequential state is always assigned with <= so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

  for (genvar k = 0; k < MAT_WORDS; k++) begin : g_matrix
    assign matrix[k*WORD_W +: WORD_W] = mem[MAT_BASE + k];
  end

endmodule

// File: rtl/matrix_mem_responder.sv
// Load/store responder: accepts one request, waits WAIT_CYCLES, accesses a
// local word array and returns a response. Words 0..8 drive d11..d33.
// Optional address range checking: MATRIX_MEM_RESPONDER_ADDR_CHECK_EN.
module matrix_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] d11,
  output logic [31:0] d12,
  output logic [31:0] d13,
  output logic [31:0] d21,
  output logic [31:0] d22,
  output logic [31:0] d23,
  output logic [31:0] d31,
  output logic [31:0] d32,
  output logic [31:0] d33
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t state, next_state;

  logic                        we_q;
  logic                        err_q;
  logic [IDX_W-1:0]            idx_q;
  logic [WORD_W-1:0]           wdata_q;
  logic [3:0]                  cnt_q;
  logic [WORD_W-1:0]           rdata_q;
  logic                        rerr_q;

  logic                        accept;
  logic                        access;
  logic                        req_err;
  logic                        acc_we;
  logic                        acc_err;
  logic [IDX_W-1:0]            acc_idx;
  logic [WORD_W-1:0]           acc_wdata;
  logic [WORD_W-1:0]           mem_rdata;
  logic [MAT_WORDS*WORD_W-1:0] matrix;

`ifdef MATRIX_MEM_RESPONDER_ADDR_CHECK_EN
  assign req_err = addr_out_of_range(req_addr, IDX_W);
`else
  // Upper address bits are deliberately ignored: addresses wrap modulo DEPTH.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[WORD_W-1:IDX_W];
  assign req_err        = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    access     = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (NO_WAIT) begin
            access     = 1'b1;
            next_state = RESP;
          end else begin
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          access     = 1'b1;
          next_state = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // With no wait states the access happens on the acceptance edge, so it
  // must use the live request rather than the (not yet loaded) latches.
  assign acc_we    = NO_WAIT ? req_we                : we_q;
  assign acc_err   = NO_WAIT ? req_err               : err_q;
  assign acc_idx   = NO_WAIT ? req_addr[IDX_W-1:0]   : idx_q;
  assign acc_wdata = NO_WAIT ? req_wdata             : wdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      cnt_q   <= 4'd0;
    end else if (accept) begin
      we_q    <= req_we;
      err_q   <= req_err;
      idx_q   <= req_addr[IDX_W-1:0];
      wdata_q <= req_wdata;
      cnt_q   <= CNT_INIT;
    end else if (state == WAIT && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Response data is captured at the access edge and held through RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else if (access) begin
      rdata_q <= (acc_we || acc_err) ? '0 : mem_rdata;
      rerr_q  <= acc_err;
    end else if (rsp_valid && rsp_ready) begin
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = rerr_q;

  mem_word_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk    (clk),
    .reset  (reset),
    .we     (access && acc_we && !acc_err),
    .waddr  (acc_idx),
    .wdata  (acc_wdata),
    .raddr  (acc_idx),
    .rdata  (mem_rdata),
    .matrix (matrix)
  );

  assign d11 = matrix[0*WORD_W +: WORD_W];
  assign d12 = matrix[1*WORD_W +: WORD_W];
  assign d13 = matrix[2*WORD_W +: WORD_W];
  assign d21 = matrix[3*WORD_W +: WORD_W];
  assign d22 = matrix[4*WORD_W +: WORD_W];
  assign d23 = matrix[5*WORD_W +: WORD_W];
  assign d31 = matrix[6*WORD_W +: WORD_W];
  assign d32 = matrix[7*WORD_W +: WORD_W];
  assign d33 = matrix[8*WORD_W +: WORD_W];

endmodule

// File: tb/tb_matrix_mem_responder.sv
// Randomized self-checking bench for matrix_mem_responder against a plain
// array model; a second instance covers the zero-wait-state build.
module tb_matrix_mem_responder;

  localparam int DEPTH       = 64;
  localparam int WAIT_CYCLES = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [31:0] dm [9];

  logic        z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
  logic [31:0] zdm [9];

  matrix_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .d11(dm[0]), .d12(dm[1]), .d13(dm[2]), .d21(dm[3]), .d22(dm[4]),
    .d23(dm[5]), .d31(dm[6]), .d32(dm[7]), .d33(dm[8])
  );

  matrix_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err),
    .d11(zdm[0]), .d12(zdm[1]), .d13(zdm[2]), .d21(zdm[3]), .d22(zdm[4]),
    .d23(zdm[5]), .d31(zdm[6]), .d32(zdm[7]), .d33(zdm[8])
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] model  [DEPTH];
  logic [31:0] zmodel [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic exp_err(input logic [31:0] addr);
`ifdef MATRIX_MEM_RESPONDER_ADDR_CHECK_EN
    return addr >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_matrix(input string tag);
    for (int k = 0; k < 9; k++)
      check($sformatf("%s_d%0d%0d", tag, k / 3 + 1, k % 3 + 1), dm[k], model[k]);
  endtask

  task automatic clear_models();
    for (int i = 0; i < DEPTH; i++) begin
      model[i]  = '0;
      zmodel[i] = '0;
    end
  endtask

  // One full transaction on the WAIT_CYCLES instance, holding rsp_ready low
  // for 'hold' response cycles before the handshake.
  task automatic txn(input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input int hold);
    logic        e;
    logic [31:0] exp_rd;
    int          idx;
    int          lat;
    idx    = int'(addr % DEPTH);
    e      = exp_err(addr);
    exp_rd = (we || e) ? 32'd0 : model[idx];
    @(negedge clk);
    check("pre_req_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    if (we && !e) model[idx] = wdata;
    lat = 1;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1 || lat >= 20) break;
      check("busy_req_ready", req_ready, 1'b0);
      lat++;
    end
    check("latency", 32'(lat), 32'(WAIT_CYCLES + 1));
    check("rsp_valid", rsp_valid, 1'b1);
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("rsp_err", rsp_err, e);
    check_matrix("mat");
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_rsp_valid", rsp_valid, 1'b1);
      check("hold_rsp_rdata", rsp_rdata, exp_rd);
      check("hold_req_ready", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("idle_req_ready", req_ready, 1'b1);
    check("idle_rsp_valid", rsp_valid, 1'b0);
  endtask

  // req_valid and rsp_ready held high; writes to words 16..16+n-1.
  task automatic stream(input int n);
    logic [31:0] data [$];
    int sent, done, cyc;
    logic acc, hs;
    sent = 0; done = 0; cyc = 0;
    for (int i = 0; i < n; i++) data.push_back($urandom);
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd16; req_wdata = data[0];
    while (done < n && cyc < 300) begin
      acc = req_ready & req_valid;
      hs  = rsp_valid;
      @(negedge clk);
      cyc++;
      if (acc) begin
        model[16 + sent] = data[sent];
        sent++;
        if (sent < n) begin
          req_addr = 32'(16 + sent); req_wdata = data[sent];
        end else begin
          req_valid = 1'b0;
        end
      end
      if (hs) begin
        done++;
        check("b2b_idle_after_hs", {30'd0, req_ready, rsp_valid}, 32'b10);
      end
    end
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("b2b_accepted", 32'(sent), 32'(n));
    check("b2b_responses", 32'(done), 32'(n));
  endtask

  // One transaction on the zero-wait-state instance.
  task automatic txn0(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] exp_rd;
    int idx;
    idx    = int'(addr % DEPTH);
    exp_rd = (we || exp_err(addr)) ? 32'd0 : zmodel[idx];
    @(negedge clk);
    check("w0_pre_ready", z_req_ready, 1'b1);
    z_req_valid = 1'b1; z_req_we = we; z_req_addr = addr; z_req_wdata = wdata;
    @(posedge clk);
    #1;
    z_req_valid = 1'b0;
    if (we && !exp_err(addr)) zmodel[idx] = wdata;
    @(negedge clk);
    check("w0_rsp_valid_lat1", z_rsp_valid, 1'b1);
    check("w0_rsp_rdata", z_rsp_rdata, exp_rd);
    for (int k = 0; k < 9; k++) check("w0_mat", zdm[k], zmodel[k]);
    z_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    z_rsp_ready = 1'b0;
    @(negedge clk);
    check("w0_idle_ready", z_req_ready, 1'b1);
    check("w0_idle_rsp_valid", z_rsp_valid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_rsp_ready = 1'b0;
    clear_models();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check_matrix("rst");

    txn(1'b1, 32'd0, 32'h11, 0);
    txn(1'b1, 32'd8, 32'h99, 1);
    txn(1'b1, 32'd5, 32'hDEADBEEF, 0);
    txn(1'b0, 32'd5, 32'h0, 4);
    txn(1'b1, 32'd64, 32'h55, 0);
    txn(1'b0, 32'd64, 32'h0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = ($urandom_range(7, 0) == 0) ? 32'(DEPTH + $urandom_range(200, 0))
                                      : 32'($urandom_range(15, 0));
      txn(1'($urandom), a, $urandom, int'($urandom_range(3, 0)));
    end

    stream(6);
    for (int i = 0; i < 6; i++) txn(1'b0, 32'(16 + i), 32'h0, 0);

    // Reset asserted mid-WAIT of a write to word 4.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd4; req_wdata = 32'hA5A5_5A5A;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    clear_models();
    @(negedge clk);
    reset = 1'b0;
    check("midrst_req_ready", req_ready, 1'b1);
    check("midrst_rsp_valid", rsp_valid, 1'b0);
    check_matrix("midrst");
    repeat (5) @(negedge clk);
    check("midrst_no_late_rsp", rsp_valid, 1'b0);
    check("midrst_d22", dm[4], 32'd0);
    txn(1'b0, 32'd4, 32'h0, 0);

    txn0(1'b1, 32'd3, 32'h0000_3333);
    txn0(1'b0, 32'd3, 32'h0);
    for (int i = 0; i < 8; i++)
      txn0(1'($urandom), 32'($urandom_range(11, 0)), $urandom);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
